mips_mem_arbiter: RTL

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

---
 rtl/mips_mem_arbiter.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_mem_arbiter.sv
// Three-port (loader > data > fetch) arbiter onto a single-port synchronous memory.
// Optional fetch anti-starvation enabled by defining MIPS_ARB_STARVE_EN.
module mips_mem_arbiter #(
   parameter int AW           = 10,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic [DW-1:0] ld_rdata,
   output logic          ld_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, ACK = 2'd2} state_t;
   typedef enum logic [1:0] {W_LD = 2'd0, W_D = 2'd1, W_IF = 2'd2} win_t;

   state_t        state_r;
   win_t          win_r;
   win_t          win_s;
   logic          grant_s;
   logic          starve_force_s;
   logic          we_r;
   logic          we_s;
   logic [AW-1:0] addr_s;
   logic [DW-1:0] wdata_s;
   logic [DW-1:0] rsp_s;
   logic          mem_en_r;
   logic          mem_we_r;
   logic [AW-1:0] mem_addr_r;
   logic [DW-1:0] mem_wdata_r;
   logic          busy_r;
   logic          ld_ack_r;
   logic          d_ack_r;
   logic          if_ack_r;
   logic [DW-1:0] ld_rdata_r;
   logic [DW-1:0] d_rdata_r;
   logic [DW-1:0] if_rdata_r;

`ifdef MIPS_ARB_STARVE_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt_r;

   assign starve_force_s = (starve_cnt_r == LIMIT_C);

   // Count IDLE grants lost by a waiting fetch; any fetch grant or idle fetch clears it
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_r <= '0;
      end else if (state_r == IDLE) begin
         if (!if_req) begin
            starve_cnt_r <= '0;
         end else if (grant_s && (win_s == W_IF)) begin
            starve_cnt_r <= '0;
         end else if (grant_s && !starve_force_s) begin
            starve_cnt_r <= starve_cnt_r + CW'(1);
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end
`else
   assign starve_force_s = 1'b0;
`endif

   // Winner selection; a starved fetch jumps ahead of data but never ahead of the loader
   always_comb begin
      grant_s = 1'b0;
      win_s   = W_LD;
      if (ld_req) begin
         grant_s = 1'b1;
         win_s   = W_LD;
      end else if (starve_force_s && if_req) begin
         grant_s = 1'b1;
         win_s   = W_IF;
      end else if (d_req) begin
         grant_s = 1'b1;
         win_s   = W_D;
      end else if (if_req) begin
         grant_s = 1'b1;
         win_s   = W_IF;
      end else begin
         grant_s = 1'b0;
         win_s   = W_LD;
      end
   end

   // Request fields of the selected port; fetch is read-only
   always_comb begin
      addr_s  = '0;
      we_s    = 1'b0;
      wdata_s = '0;
      case (win_s)
         W_LD: begin
            addr_s  = ld_addr;
            we_s    = ld_we;
            wdata_s = ld_wdata;
         end
         W_D: begin
            addr_s  = d_addr;
            we_s    = d_we;
            wdata_s = d_wdata;
         end
         W_IF: begin
            addr_s  = if_addr;
            we_s    = 1'b0;
            wdata_s = '0;
         end
         default: begin
            addr_s  = '0;
            we_s    = 1'b0;
            wdata_s = '0;
         end
      endcase
   end

   // Write grants return zero so the rdata of a write is deterministic
   assign rsp_s = we_r ? '0 : mem_rdata;

   // Transaction FSM: IDLE latches the winner, MEM strobes memory, ACK returns data
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         win_r       <= W_LD;
         we_r        <= 1'b0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         busy_r      <= 1'b0;
         ld_ack_r    <= 1'b0;
         d_ack_r     <= 1'b0;
         if_ack_r    <= 1'b0;
         ld_rdata_r  <= '0;
         d_rdata_r   <= '0;
         if_rdata_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_s) begin
                  state_r     <= MEM;
                  win_r       <= win_s;
                  we_r        <= we_s;
                  mem_en_r    <= 1'b1;
                  mem_we_r    <= we_s;
                  mem_addr_r  <= addr_s;
                  mem_wdata_r <= wdata_s;
                  busy_r      <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            MEM: begin
               state_r  <= ACK;
               mem_en_r <= 1'b0;
               mem_we_r <= 1'b0;
               ld_ack_r <= (win_r == W_LD);
               d_ack_r  <= (win_r == W_D);
               if_ack_r <= (win_r == W_IF);
            end
            ACK: begin
               state_r  <= IDLE;
               busy_r   <= 1'b0;
               ld_ack_r <= 1'b0;
               d_ack_r  <= 1'b0;
               if_ack_r <= 1'b0;
               case (win_r)
                  W_LD:    ld_rdata_r <= rsp_s;
                  W_D:     d_rdata_r  <= rsp_s;
                  W_IF:    if_rdata_r <= rsp_s;
                  default: ld_rdata_r <= ld_rdata_r;
               endcase
            end
            default: begin
               state_r  <= IDLE;
               mem_en_r <= 1'b0;
               mem_we_r <= 1'b0;
               busy_r   <= 1'b0;
               ld_ack_r <= 1'b0;
               d_ack_r  <= 1'b0;
               if_ack_r <= 1'b0;
            end
         endcase
      end
   end

   // Read data passes straight through during ACK, then the held copy takes over
   always_comb begin
      if (ld_ack_r) begin
         ld_rdata = rsp_s;
      end else begin
         ld_rdata = ld_rdata_r;
      end
      if (d_ack_r) begin
         d_rdata = rsp_s;
      end else begin
         d_rdata = d_rdata_r;
      end
      if (if_ack_r) begin
         if_rdata = rsp_s;
      end else begin
         if_rdata = if_rdata_r;
      end
   end

   assign ld_ack    = ld_ack_r;
   assign d_ack     = d_ack_r;
   assign if_ack    = if_ack_r;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign busy      = busy_r;

endmodule
